// File: rtl/master_control.sv
// Master-side handshake controller: latches a value on send, shows notice,
// then runs a request/ack/valid handshake with a 2-flop synchronized ack and timeout.
module master_control #(
  parameter int unsigned NOTICE_CYCLES  = 100_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [2:0] data_to_send,
  input  logic       ack,
  output logic       request,
  output logic       valid,
  output logic [2:0] data_out,
  output logic       notice,
  output logic       error
);

  localparam int unsigned MAXC = (NOTICE_CYCLES > TIMEOUT_CYCLES) ? NOTICE_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_NOTICE,
    S_WAIT_ACK,
    S_SEND_DATA
  } state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      data_reg_q;
  logic [2:0]      data_out_q;
  logic            ack_s1_q, ack_s2_q;
  logic            request_q, valid_q, notice_q, error_q;

  // The counter holds the number of cycles already spent in the state, so the
  // terminal compare is against N-1 to give exactly N cycles of notice/request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      data_reg_q <= '0;
      data_out_q <= '0;
      ack_s1_q   <= 1'b0;
      ack_s2_q   <= 1'b0;
      request_q  <= 1'b0;
      valid_q    <= 1'b0;
      notice_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      ack_s1_q <= ack;
      ack_s2_q <= ack_s1_q;
      case (state_q)
        S_IDLE: begin
          request_q <= 1'b0;
          valid_q   <= 1'b0;
          notice_q  <= 1'b0;
          cnt_q     <= '0;
          if (send) begin
            data_reg_q <= data_to_send;
            error_q    <= 1'b0;
            notice_q   <= 1'b1;
            state_q    <= S_NOTICE;
          end
        end
        S_NOTICE: begin
          if (cnt_q == CW'(NOTICE_CYCLES - 1)) begin
            notice_q  <= 1'b0;
            request_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_WAIT_ACK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WAIT_ACK: begin
          if (ack_s2_q) begin
            request_q  <= 1'b0;
            data_out_q <= data_reg_q;
            valid_q    <= 1'b1;
            cnt_q      <= '0;
            state_q    <= S_SEND_DATA;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            request_q <= 1'b0;
            error_q   <= 1'b1;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SEND_DATA: begin
          cnt_q <= '0;
          if (!ack_s2_q) begin
            valid_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign request  = request_q;
  assign valid    = valid_q;
  assign data_out = data_out_q;
  assign notice   = notice_q;
  assign error    = error_q;

endmodule

// File: tb/tb_master_control.sv
// Directed bench for master_control with NOTICE_CYCLES=4, TIMEOUT_CYCLES=16;
// inputs driven and outputs sampled on the falling clock edge.
module tb_master_control;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [2:0] data_to_send;
  logic       ack;
  logic       request, valid, notice, error;
  logic [2:0] data_out;

  int checks   = 0;
  int failures = 0;

  master_control #(
    .NOTICE_CYCLES (4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send        (send),
    .data_to_send(data_to_send),
    .ack         (ack),
    .request     (request),
    .valid       (valid),
    .data_out    (data_out),
    .notice      (notice),
    .error       (error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  // Full transfer starting at a falling edge with the DUT idle and ack low.
  // Ends at the falling edge right after valid drops (DUT back in S_IDLE).
  task automatic run_transfer(input logic [2:0] d, input bit disturb, input string tag);
    data_to_send = d;
    send = 1'b1;
    tick();
    send = 1'b0;
    data_to_send = ~d;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({notice, request, valid, error} !== 4'b1000) begin
        failures++;
        $display("FAIL %s notice_phase[%0d]: nrve=%b expected 1000", tag, i, {notice, request, valid, error});
      end
      if (disturb && i == 0) begin
        ack = 1'b1;
        send = 1'b1;
        data_to_send = 3'b010;
      end
      if (disturb && i == 1) begin
        ack = 1'b0;
        send = 1'b0;
      end
      tick();
    end
    checks++;
    if ({notice, request, valid} !== 3'b010) begin
      failures++;
      $display("FAIL %s request_rise: nrv=%b expected 010", tag, {notice, request, valid});
    end
    tick();
    tick();
    ack = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({request, valid} !== 2'b10) begin
        failures++;
        $display("FAIL %s ack_sync[%0d]: rv=%b expected 10", tag, i, {request, valid});
      end
    end
    tick();
    checks++;
    if ({request, valid, data_out} !== {2'b01, d}) begin
      failures++;
      $display("FAIL %s data_valid: rv=%b data=%0d expected rv=01 data=%0d", tag, {request, valid}, data_out, d);
    end
    tick();
    tick();
    ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if ({request, valid, data_out} !== {2'b01, d}) begin
        failures++;
        $display("FAIL %s valid_hold[%0d]: rv=%b data=%0d expected rv=01 data=%0d", tag, i, {request, valid}, data_out, d);
      end
    end
    tick();
    checks++;
    if ({notice, request, valid, error, data_out} !== {4'b0000, d}) begin
      failures++;
      $display("FAIL %s valid_drop: nrve=%b data=%0d expected 0000 data=%0d", tag, {notice, request, valid, error}, data_out, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    send = 1'b1;
    ack = 1'b1;
    data_to_send = 3'b111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({notice, request, valid, error, data_out} !== 7'b0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: outputs=%b expected 0000000", i, {notice, request, valid, error, data_out});
      end
    end
    rst = 1'b0;
    send = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({notice, request, valid, error, data_out} !== 7'b0) begin
        failures++;
        $display("FAIL reset_idle[%0d]: outputs=%b expected 0000000", i, {notice, request, valid, error, data_out});
      end
    end
  endtask

  task automatic test_normal();
    run_transfer(3'b101, 1'b0, "normal");
    tick();
  endtask

  task automatic test_timeout();
    data_to_send = 3'b011;
    send = 1'b1;
    tick();
    send = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({notice, request, valid, error} !== 4'b0100) begin
        failures++;
        $display("FAIL timeout_request[%0d]: nrve=%b expected 0100", i, {notice, request, valid, error});
      end
      tick();
    end
    checks++;
    if ({notice, request, valid, error, data_out} !== 7'b0001101) begin
      failures++;
      $display("FAIL timeout_abort: nrve=%b data=%0d expected 0001 data=5", {notice, request, valid, error}, data_out);
    end
    tick();
    tick();
    checks++;
    if ({notice, request, error} !== 3'b001) begin
      failures++;
      $display("FAIL timeout_sticky: nre=%b expected 001", {notice, request, error});
    end
    // The next transfer must clear error on acceptance (checked inside).
    run_transfer(3'b100, 1'b0, "after_timeout");
    tick();
  endtask

  task automatic test_ignored();
    run_transfer(3'b101, 1'b1, "ignored");
    tick();
    tick();
    checks++;
    if ({notice, request, valid, data_out} !== 6'b000101) begin
      failures++;
      $display("FAIL ignored_no_requeue: nrv=%b data=%0d expected 000 data=5", {notice, request, valid}, data_out);
    end
  endtask

  task automatic test_back_to_back();
    run_transfer(3'b001, 1'b0, "b2b_first");
    checks++;
    if (data_out !== 3'd1) begin
      failures++;
      $display("FAIL b2b_first_hold: data=%0d expected 1", data_out);
    end
    run_transfer(3'b110, 1'b0, "b2b_second");
    tick();
    checks++;
    if (data_out !== 3'd6) begin
      failures++;
      $display("FAIL b2b_second_hold: data=%0d expected 6", data_out);
    end
  endtask

  task automatic test_mid_reset();
    data_to_send = 3'b111;
    send = 1'b1;
    tick();
    send = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    ack = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({request, valid, data_out} !== 5'b01111) begin
      failures++;
      $display("FAIL mid_reset_setup: rv=%b data=%0d expected rv=01 data=7", {request, valid}, data_out);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({notice, request, valid, error, data_out} !== 7'b0) begin
      failures++;
      $display("FAIL mid_reset_clear: outputs=%b expected 0000000", {notice, request, valid, error, data_out});
    end
    rst = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({notice, request, valid, data_out} !== 6'b0) begin
      failures++;
      $display("FAIL mid_reset_idle: outputs=%b expected 000000", {notice, request, valid, data_out});
    end
    run_transfer(3'b110, 1'b0, "post_reset");
  endtask

  initial begin
    rst = 1'b1;
    send = 1'b0;
    ack = 1'b0;
    data_to_send = '0;
    tick();
    test_reset();
    test_normal();
    test_timeout();
    test_ignored();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/master_control.md
# master_control

Master-side handshake controller for the chip-to-chip link; the upstream stage that drives `slave_control` on the partner board. On a one-cycle `send` pulse it latches a 3-bit value, asserts `notice` for a fixed interval, raises `request`, waits for the slave's `ack`, then presents the data with `valid` until the slave drops `ack`. An ack timeout aborts a transfer to a silent slave and flags `error`.

## Interface
- `NOTICE_CYCLES`, default 100_000_000: `notice` high time before `request` (1 s at 100 MHz); must be ≥1.
- `TIMEOUT_CYCLES`, default 500_000_000: maximum cycles in S_WAIT_ACK before abort; must be ≥1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `send`  in  1  one-cycle pulse (already debounced and one-pulsed) starting a transfer.
- `data_to_send`  in  3  value to transmit; sampled only on an accepted `send`.
- `ack`  in  1  acknowledge from the slave board; asynchronous to `clk`.
- `request`  out  1  request to slave.
- `valid`  out  1  qualifies `data_out` to slave.
- `data_out`  out  3  data to slave.
- `notice`  out  1  LED indication of a transfer starting.
- `error`  out  1  sticky ack-timeout flag.

## Operation
- `ack` passes through a 2-flop synchronizer (`ack_s1`, `ack_s2`); FSM uses `ack_s2` only. Synchronizer flops reset to 0.
- All outputs are registers. Reset values: `request`=0, `valid`=0, `data_out`=0, `notice`=0, `error`=0, state=S_IDLE, counters=0.
- One cycle counter (width sufficient for max(NOTICE_CYCLES, TIMEOUT_CYCLES)), cleared on every state change.
- S_IDLE: `request`=0, `valid`=0, `notice`=0. On `send`=1: `data_reg`←`data_to_send`, `error`←0, go S_NOTICE.
- S_NOTICE: `notice`=1. After NOTICE_CYCLES cycles in state: `notice`←0, `request`←1, go S_WAIT_ACK.
- S_WAIT_ACK: `request` held 1. If `ack_s2`=1: `request`←0, `data_out`←`data_reg`, `valid`←1, go S_SEND_DATA. Else if counter reaches TIMEOUT_CYCLES: `request`←0, `error`←1, go S_IDLE. Ack takes priority when both occur on the same cycle.
- S_SEND_DATA: `valid`=1, `data_out` stable. When `ack_s2`=0: `valid`←0, go S_IDLE. No timeout in this state.
- `data_out` holds its last transmitted value after the transfer; it changes only on entry to S_SEND_DATA or on reset.
- `send` outside S_IDLE is ignored and not queued; `data_to_send` changes after acceptance have no effect.
- `ack`=1 observed in S_IDLE or S_NOTICE is ignored.
- `rst` mid-transfer: all outputs return to reset values at the next edge; no partial handshake is completed.

## Timing
- `send` high at edge k → `notice`=1 from edge k+1.
- `notice` high for exactly NOTICE_CYCLES cycles; `request` rises on the same edge `notice` falls.
- `ack` first captured by `ack_s1` at edge t → `ack_s2`=1 after t+1 → `request` falls and `valid`/`data_out` update at edge t+2.
- Drop of `ack` is seen with the same 2-cycle synchronizer delay; `valid` falls at edge t'+2, where t' is the first edge that captures `ack`=0.
- Earliest next `send` acceptance: the cycle after returning to S_IDLE.
- Timeout: `request` high for exactly TIMEOUT_CYCLES cycles, then `request` falls and `error` rises on the same edge.
- `request` and `valid` are never high in the same cycle.

## Test plan
Benches use NOTICE_CYCLES=4 and TIMEOUT_CYCLES=16.
- Reset: hold `rst`=1 for 3 cycles with `send`=1 and `ack`=1 → all outputs 0; after release the FSM stays in S_IDLE until a fresh `send` pulse.
- Normal transfer: `data_to_send`=3'b101 and `send` pulse at edge k; `ack` model rises 2 cycles after `request` and falls 2 cycles after `valid` → `notice` high for edges k+1..k+4; `request` high from k+5; `data_out`=5 with `valid`=1 at ack-capture+2; `valid` falls at ack-drop-capture+2; `error`=0.
- Timeout: `send` pulse with `ack` held 0 → `request` high for exactly 16 cycles, then `error`=1 and the FSM returns to S_IDLE. A following `send` clears `error` on acceptance.
- Ignored inputs: second `send` with `data_to_send`=3'b010 during S_NOTICE; `ack` pulsed during S_NOTICE → no effect; the transfer completes with `data_out`=5.
- Back-to-back: transfers of 3'b001 then 3'b110, each `send` issued the cycle after `valid` falls → both complete; `data_out` reads 1 then 6; `request` and `valid` are never high together.
- Mid-transfer reset: assert `rst` during S_SEND_DATA → `valid`=0 and `data_out`=0 at the next edge; the next transfer completes normally.
